// File: rtl/coffee_panel_pkg.sv
// ============================================================================
// Module   : coffee_panel_pkg
// Purpose  : Shared constants, segment table and monitor state type for the
//            coffee panel display path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package coffee_panel_pkg;

  localparam int N_TYPES = 3;

  localparam logic [3:0] CH_BLANK = 4'd15;
  localparam logic [3:0] ST_FIRST = 4'd3;
  localparam logic [3:0] ST_LAST  = 4'd8;

  // Which character codes each display may legally show (bit i = code i).
  localparam logic [15:0] TYPE_LEGAL_MASK  = 16'h0007;
  localparam logic [15:0] STATE_LEGAL_MASK = 16'h81F8;

  // Active-low segments {g,f,e,d,c,b,a} indexed by character code.
  // Entry 15 is the blank (all segments off).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h7F, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    IDLE   = 2'd1,
    BREW   = 2'd2,
    FINISH = 2'd3
  } mon_state_t;

  // Inverse of the display decoder: returns {hit, code}.
  function automatic logic [4:0] seg_lookup(input logic [6:0] pattern);
    logic [4:0] v_result;
    v_result = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (SEG_LUT[i] == pattern) v_result = {1'b1, 4'(i)};
    end
    return v_result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_stable_decode.sv
// ============================================================================
// Module   : seg_stable_decode
// Purpose  : Synchronizes one seven-segment display, waits for the pattern to
//            settle and decodes it back to a character code.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_stable_decode
  import coffee_panel_pkg::*;
#(
  parameter int          STABLE_CYCLES = 4,
  parameter int          CODE_W        = 4,
  parameter logic [15:0] LEGAL_MASK    = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        i_seg,
  output logic              o_accept,
  output logic [CODE_W-1:0] o_code,
  output logic              o_legal
);

  localparam int               c_cnt_w  = $clog2(STABLE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_stable = c_cnt_w'(STABLE_CYCLES);

  logic [6:0]         r_sync1;
  logic [6:0]         r_sync2;
  logic [1:0]         r_sync_vld;
  logic [c_cnt_w-1:0] r_cnt;
  logic [6:0]         r_last;
  logic               r_have_last;

  logic [4:0]         w_lookup;
  logic               w_new;
  logic               w_accept;

  assign w_lookup = seg_lookup(r_sync2);
  assign w_new    = !r_have_last || (r_sync2 != r_last);
  // r_sync_vld keeps the reset value of the synchronizer from counting as data.
  assign w_accept = r_sync_vld[1] && (r_cnt == c_stable) && w_new;

  assign o_accept = w_accept;
  assign o_code   = w_lookup[CODE_W-1:0];
  assign o_legal  = w_lookup[4] && LEGAL_MASK[w_lookup[3:0]];

  // Two-flop synchronizer plus a marker of when its output is real input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 7'h7F;
      r_sync2    <= 7'h7F;
      r_sync_vld <= 2'b00;
    end else begin
      r_sync1    <= i_seg;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  // Count how many cycles r_sync2 has held its current value (saturating).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!r_sync_vld[1] || (r_sync1 != r_sync2)) begin
      r_cnt <= c_cnt_w'(1);
    end else if (r_cnt != c_stable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Remember the last accepted pattern so a re-settle is not a new event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last      <= 7'h7F;
      r_have_last <= 1'b0;
    end else if (w_accept) begin
      r_last      <= r_sync2;
      r_have_last <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/coffee_display_monitor.sv
// ============================================================================
// Module   : coffee_display_monitor
// Purpose  : Passive observer of the coffee panel displays: decodes them,
//            tracks the brew sequence, counts brews and flags errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coffee_display_monitor
  import coffee_panel_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               seg_type,
  input  logic [6:0]               seg_state,
  input  logic [4:0]               led,
  input  logic                     clear_errors,
  output logic [1:0]               type_code,
  output logic                     type_valid,
  output logic [3:0]               state_code,
  output logic                     state_valid,
  output logic                     brew_done,
  output logic [N_TYPES*CNT_W-1:0] brew_count,
  output logic                     led_seen,
  output logic                     illegal_pattern,
  output logic                     seq_error
);

  logic             w_t_acc, w_t_legal, w_s_acc, w_s_legal;
  logic [1:0]       w_t_code;
  logic [3:0]       w_s_code;
  logic             w_state_ev, w_type_valid_eff;
  logic [1:0]       w_type_code_eff;

  mon_state_t       r_state, w_state_next;
  logic [3:0]       r_expected, w_expected_next;
  logic             w_seq_err, w_done, w_start;

  logic [1:0]       r_type_code, r_brew_type;
  logic             r_type_valid, r_state_valid, r_brew_done;
  logic [3:0]       r_state_code;
  logic [4:0]       r_led_s1, r_led_s2;
  logic             r_led_seen, r_illegal, r_seq_error;
  logic [CNT_W-1:0] r_count [N_TYPES];

  seg_stable_decode #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CODE_W        (2),
    .LEGAL_MASK    (TYPE_LEGAL_MASK)
  ) u_type_dec (
    .clk      (clk),
    .reset    (reset),
    .i_seg    (seg_type),
    .o_accept (w_t_acc),
    .o_code   (w_t_code),
    .o_legal  (w_t_legal)
  );

  seg_stable_decode #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CODE_W        (4),
    .LEGAL_MASK    (STATE_LEGAL_MASK)
  ) u_state_dec (
    .clk      (clk),
    .reset    (reset),
    .i_seg    (seg_state),
    .o_accept (w_s_acc),
    .o_code   (w_s_code),
    .o_legal  (w_s_legal)
  );

  // A type accepted this cycle takes effect before a brew start in the same cycle.
  assign w_type_valid_eff = w_t_acc ? w_t_legal : r_type_valid;
  assign w_type_code_eff  = (w_t_acc && w_t_legal) ? w_t_code : r_type_code;
  assign w_state_ev       = w_s_acc && w_s_legal;

  // Decoded display registers; illegal patterns drop valid but keep the code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_type_code   <= 2'd0;
      r_type_valid  <= 1'b0;
      r_state_code  <= CH_BLANK;
      r_state_valid <= 1'b0;
    end else begin
      if (w_t_acc) begin
        r_type_valid <= w_t_legal;
        if (w_t_legal) r_type_code <= w_t_code;
      end
      if (w_s_acc) begin
        r_state_valid <= w_s_legal;
        if (w_s_legal) r_state_code <= w_s_code;
      end
    end
  end

  // Sequence FSM next state, driven only by legal accepted state events.
  always_comb begin
    w_state_next    = r_state;
    w_expected_next = r_expected;
    w_seq_err       = 1'b0;
    w_done          = 1'b0;
    w_start         = 1'b0;
    if (w_state_ev) begin
      case (r_state)
        SYNC: begin
          if (w_s_code == CH_BLANK) w_state_next = IDLE;
        end
        IDLE: begin
          if (w_s_code == ST_FIRST && w_type_valid_eff) begin
            w_state_next    = BREW;
            w_start         = 1'b1;
            w_expected_next = ST_FIRST + 4'd1;
          end else begin
            w_seq_err    = 1'b1;
            w_state_next = SYNC;
          end
        end
        BREW: begin
          if (w_s_code == r_expected) begin
            if (w_s_code == ST_LAST) w_state_next = FINISH;
            else w_expected_next = r_expected + 4'd1;
          end else begin
            w_seq_err    = 1'b1;
            w_state_next = SYNC;
          end
        end
        FINISH: begin
          if (w_s_code == CH_BLANK) begin
            w_done       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_seq_err    = 1'b1;
            w_state_next = SYNC;
          end
        end
        default: w_state_next = SYNC;
      endcase
    end
  end

  // FSM state, expected step, latched brew type and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SYNC;
      r_expected  <= ST_FIRST;
      r_brew_type <= 2'd0;
      r_brew_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_expected  <= w_expected_next;
      r_brew_done <= w_done;
      if (w_start) r_brew_type <= w_type_code_eff;
    end
  end

  // Saturating per-type brew counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_TYPES; i++) r_count[i] <= '0;
    end else begin
      for (int i = 0; i < N_TYPES; i++) begin
        if (w_done && r_brew_type == 2'(i) && r_count[i] != {CNT_W{1'b1}})
          r_count[i] <= r_count[i] + 1'b1;
      end
    end
  end

  // LED synchronizer and activity flag; a completed brew clears it first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led_s1   <= 5'd0;
      r_led_s2   <= 5'd0;
      r_led_seen <= 1'b0;
    end else begin
      r_led_s1 <= led;
      r_led_s2 <= r_led_s1;
      if (w_done) r_led_seen <= 1'b0;
      else if (r_led_s2 != 5'd0) r_led_seen <= 1'b1;
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal   <= 1'b0;
      r_seq_error <= 1'b0;
    end else begin
      if ((w_t_acc && !w_t_legal) || (w_s_acc && !w_s_legal)) r_illegal <= 1'b1;
      else if (clear_errors) r_illegal <= 1'b0;
      if (w_seq_err) r_seq_error <= 1'b1;
      else if (clear_errors) r_seq_error <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_TYPES; g++) begin : g_count_out
    assign brew_count[g*CNT_W +: CNT_W] = r_count[g];
  end

  assign type_code       = r_type_code;
  assign type_valid      = r_type_valid;
  assign state_code      = r_state_code;
  assign state_valid     = r_state_valid;
  assign brew_done       = r_brew_done;
  assign led_seen        = r_led_seen;
  assign illegal_pattern = r_illegal;
  assign seq_error       = r_seq_error;

endmodule

`default_nettype wire

// File: tb/tb_coffee_display_monitor.sv
// ============================================================================
// Module   : tb_coffee_display_monitor
// Purpose  : Self-checking bench for coffee_display_monitor with a step-level
//            reference model of the displays and the brew sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coffee_display_monitor;

  localparam int STABLE = 4;
  localparam int CNT_W  = 8;
  localparam int HOLD   = 10;
  localparam int CMAX   = (1 << CNT_W) - 1;

  // Conventional active-high hex segment shapes {g,f,e,d,c,b,a}; 15 = blank.
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h00
  };

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [6:0]         seg_type = 7'h55;
  logic [6:0]         seg_state = 7'h55;
  logic [4:0]         led = 5'd0;
  logic               clear_errors = 1'b0;
  logic [1:0]         type_code;
  logic               type_valid;
  logic [3:0]         state_code;
  logic               state_valid;
  logic               brew_done;
  logic [3*CNT_W-1:0] brew_count;
  logic               led_seen;
  logic               illegal_pattern;
  logic               seq_error;

  coffee_display_monitor #(.STABLE_CYCLES(STABLE), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .seg_type        (seg_type),
    .seg_state       (seg_state),
    .led             (led),
    .clear_errors    (clear_errors),
    .type_code       (type_code),
    .type_valid      (type_valid),
    .state_code      (state_code),
    .state_valid     (state_valid),
    .brew_done       (brew_done),
    .brew_count      (brew_count),
    .led_seen        (led_seen),
    .illegal_pattern (illegal_pattern),
    .seq_error       (seq_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  // Reference model: m_prog is -1 when unsynchronized, 0 when idle, otherwise
  // the last brew step character seen (3..8).
  int         m_prog, m_tcode, m_scode, m_btype, m_done;
  bit         m_thave, m_shave, m_tvalid, m_svalid, m_illegal, m_seqerr, m_led;
  logic [6:0] m_tlast, m_slast;
  int         m_cnt [3];
  logic [6:0] cur_tp, cur_sp;

  always @(negedge clk) if (brew_done === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] h;
    h = HEX[d];
    return ~h;
  endfunction

  function automatic int seg_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (seg_of(i) == p) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_prog = -1; m_tcode = 0; m_scode = 15; m_btype = 0;
    m_thave = 0; m_shave = 0; m_tvalid = 0; m_svalid = 0;
    m_illegal = 0; m_seqerr = 0; m_led = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endfunction

  function automatic void model_seq(input int c, inout bit done);
    if (m_prog < 0) begin
      if (c == 15) m_prog = 0;
    end else if (m_prog == 0) begin
      if (c == 3 && m_tvalid) begin m_prog = 3; m_btype = m_tcode; end
      else begin m_seqerr = 1; m_prog = -1; end
    end else if (m_prog < 8) begin
      if (c == m_prog + 1) m_prog = c;
      else begin m_seqerr = 1; m_prog = -1; end
    end else begin
      if (c == 15) begin
        done = 1; m_done++; m_prog = 0;
        if (m_cnt[m_btype] < CMAX) m_cnt[m_btype]++;
      end else begin
        m_seqerr = 1; m_prog = -1;
      end
    end
  endfunction

  function automatic void model_step(input logic [6:0] tp, input logic [6:0] sp, input logic [4:0] lv);
    int c;
    bit done;
    done = 0;
    if (!m_thave || tp != m_tlast) begin
      m_thave = 1; m_tlast = tp; c = seg_decode(tp);
      if (c >= 0 && c <= 2) begin m_tcode = c; m_tvalid = 1; end
      else begin m_tvalid = 0; m_illegal = 1; end
    end
    if (!m_shave || sp != m_slast) begin
      m_shave = 1; m_slast = sp; c = seg_decode(sp);
      if ((c >= 3 && c <= 8) || c == 15) begin
        m_scode = c; m_svalid = 1; model_seq(c, done);
      end else begin
        m_svalid = 0; m_illegal = 1;
      end
    end
    if (done) m_led = 0;
    if (lv != 5'd0) m_led = 1;
  endfunction

  task automatic check_all();
    check("type_code", type_code, m_tcode);
    check("type_valid", type_valid, m_tvalid);
    check("state_code", state_code, m_scode);
    check("state_valid", state_valid, m_svalid);
    check("illegal_pattern", illegal_pattern, m_illegal);
    check("seq_error", seq_error, m_seqerr);
    check("led_seen", led_seen, m_led);
    for (int i = 0; i < 3; i++)
      check($sformatf("brew_count[%0d]", i), brew_count[i*CNT_W +: CNT_W], m_cnt[i]);
    check("brew_done_pulses", pulses, m_done);
  endtask

  task automatic apply_step(input logic [6:0] tp, input logic [6:0] sp, input logic [4:0] lv);
    @(negedge clk);
    seg_type = tp; seg_state = sp; led = lv;
    cur_tp = tp; cur_sp = sp;
    repeat (HOLD) @(negedge clk);
    model_step(tp, sp, lv);
    check_all();
  endtask

  task automatic do_brew(input int t);
    for (int c = 3; c <= 8; c++) apply_step(seg_of(t), seg_of(c), (c == 8) ? 5'b00001 : 5'd0);
    apply_step(seg_of(t), seg_of(15), 5'd0);
  endtask

  task automatic clear_errs();
    @(negedge clk);
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    m_illegal = 0; m_seqerr = 0;
    check("clr_illegal", illegal_pattern, 0);
    check("clr_seq_error", seq_error, 0);
  endtask

  task automatic resync(input int t);
    apply_step(seg_of(t), seg_of(4), 5'd0);
    apply_step(seg_of(t), seg_of(15), 5'd0);
    clear_errs();
  endtask

  task automatic glitch(input logic [6:0] gp, input int n);
    @(negedge clk);
    seg_state = gp;
    repeat (n) @(negedge clk);
    seg_state = cur_sp;
    repeat (HOLD) @(negedge clk);
    check_all();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; led = 5'd0; clear_errors = 1'b0;
    #1;
    check("rst_type_code", type_code, 0);
    check("rst_type_valid", type_valid, 0);
    check("rst_state_code", state_code, 15);
    check("rst_state_valid", state_valid, 0);
    check("rst_brew_done", brew_done, 0);
    check("rst_brew_count", brew_count, 0);
    check("rst_led_seen", led_seen, 0);
    check("rst_illegal", illegal_pattern, 0);
    check("rst_seq_error", seq_error, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [6:0] raw_illegal();
    logic [6:0] p;
    p = 7'($urandom);
    if (seg_decode(p) >= 0) p = 7'h55;
    return p;
  endfunction

  function automatic int next_state_char();
    if (m_prog < 0) return 15;
    if (m_prog == 0) return 3;
    if (m_prog < 8) return m_prog + 1;
    return 15;
  endfunction

  task automatic random_step();
    int r, sc, v;
    logic [6:0] tp, sp, gp;
    r = $urandom_range(0, 99);
    if (r < 75) sc = next_state_char();
    else if (r < 90) begin v = $urandom_range(3, 9); sc = (v == 9) ? 15 : v; end
    else if (r < 95) sc = $urandom_range(0, 15);
    else sc = -1;
    sp = (sc < 0) ? raw_illegal() : seg_of(sc);
    r = $urandom_range(0, 99);
    if (r < 85) tp = cur_tp;
    else if (r < 97) tp = seg_of($urandom_range(0, 2));
    else tp = seg_of($urandom_range(3, 15));
    apply_step(tp, sp, ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0);
    r = $urandom_range(0, 99);
    if (r < 8) clear_errs();
    else if (r < 16) begin
      gp = 7'($urandom);
      if (gp == cur_sp) gp = gp ^ 7'h01;
      glitch(gp, $urandom_range(1, STABLE - 1));
    end else if (r < 18) reset_dut();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    m_done = 0;
    cur_tp = 7'h55; cur_sp = 7'h55;
    reset_dut();

    // First patterns after reset appear exactly 2+STABLE cycles later.
    @(negedge clk);
    seg_type = seg_of(0); seg_state = seg_of(15);
    cur_tp = seg_type; cur_sp = seg_state;
    repeat (1 + STABLE) @(negedge clk);
    check("latency_early_state_valid", state_valid, 0);
    @(negedge clk);
    check("latency_state_valid", state_valid, 1);
    check("latency_state_code", state_code, 15);
    repeat (HOLD - 2 - STABLE) @(negedge clk);
    model_step(cur_tp, cur_sp, 5'd0);
    check_all();

    // Full brew on type 1 with LED activity during the last step.
    do_brew(1);
    check("brew1_slice1", brew_count[CNT_W +: CNT_W], 1);
    check("brew1_led_cleared", led_seen, 0);

    // Skipped step raises seq_error; recovery and a normal brew afterwards.
    apply_step(seg_of(1), seg_of(3), 5'd0);
    apply_step(seg_of(1), seg_of(4), 5'd0);
    apply_step(seg_of(1), seg_of(6), 5'd0);
    check("skip_seq_error", seq_error, 1);
    clear_errs();
    apply_step(seg_of(1), seg_of(15), 5'd0);
    do_brew(1);
    check("recover_slice1", brew_count[CNT_W +: CNT_W], 2);

    // Short glitch is filtered; the same pattern held is illegal.
    glitch(7'h55, STABLE - 1);
    check("glitch_no_illegal", illegal_pattern, 0);
    apply_step(seg_of(1), 7'h55, 5'd0);
    check("held_illegal", illegal_pattern, 1);
    check("held_state_valid", state_valid, 0);
    resync(1);

    // Type change mid-brew keeps the latched brew type.
    for (int c = 3; c <= 5; c++) apply_step(seg_of(2), seg_of(c), 5'd0);
    for (int c = 6; c <= 8; c++) apply_step(seg_of(0), seg_of(c), 5'd0);
    apply_step(seg_of(0), seg_of(15), 5'd0);
    check("midtype_slice2", brew_count[2*CNT_W +: CNT_W], 1);
    check("midtype_type_code", type_code, 0);

    // Counter saturation on type 0.
    for (int b = 0; b <= CMAX; b++) do_brew(0);
    check("sat_slice0", brew_count[0 +: CNT_W], CMAX);

    // Reset in the middle of a brew discards it.
    apply_step(seg_of(0), seg_of(3), 5'd0);
    apply_step(seg_of(0), seg_of(4), 5'd0);
    reset_dut();
    apply_step(seg_of(0), seg_of(15), 5'd0);
    check("post_reset_pulses", pulses, m_done);

    for (int k = 0; k < 300; k++) random_step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/coffee_display_monitor.md
Name: coffee_display_monitor

Overview:
- Passive observer on the coffee panel's output side: the type display, the state display and the LED bar.
- Inverts the seven-segment encoding back into character codes and filters out transient patterns.
- Tracks the brew phase sequence, counts completed brews per coffee type and flags illegal patterns or sequences.
- Used on-board as a self-check and in the bench as the scoreboard front end.

Parameters:
- STABLE_CYCLES, 4, clk cycles a synchronized pattern must hold unchanged before it is accepted (min 1).
- CNT_W, 8, width of each per-type brew counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- seg_type  input  7  type display segments, active-low, bit order {g,f,e,d,c,b,a}
- seg_state  input  7  state display segments, same encoding
- led  input  5  LED bar from the animation block
- clear_errors  input  1  synchronous pulse; clears the sticky flags
- type_code  output  2  last accepted coffee type, 0..2
- type_valid  output  1  type_code holds a legal decode
- state_code  output  4  last accepted state character, 3..8 or 15 (blank)
- state_valid  output  1  state_code holds a legal decode
- brew_done  output  1  one-cycle pulse when a full brew sequence completes
- brew_count  output  3*CNT_W  packed counters; slice i counts coffee type i
- led_seen  output  1  led was nonzero at least once since the last brew_done
- illegal_pattern  output  1  sticky; a stable pattern matched no legal code
- seq_error  output  1  sticky; an accepted state transition broke the sequence

Behaviour:
- Reset values: all outputs 0, except state_code=15. FSM enters SYNC and all counters clear. Reset mid-brew discards the brew in progress with no count and no error.
- Input conditioning:
  - seg_type, seg_state and led each pass through a 2-flop synchronizer.
  - Each display has its own stability counter, restarted whenever the synchronized pattern differs from the previous cycle's pattern.
  - A pattern is accepted when it has held STABLE_CYCLES cycles and differs from that display's last accepted pattern.
  - Latency from input change to accepted output: 2+STABLE_CYCLES clk cycles.
  - Re-accepting an identical pattern never produces an event.
- Decoding:
  - Exact 7-bit match against the shared SEG_LUT, the inverse of the display decoder.
  - Type display: codes 0..2 are legal. A match updates type_code and sets type_valid=1.
  - State display: codes 3..8 and 15 are legal. A match updates state_code and sets state_valid=1.
  - Any other pattern: the corresponding valid goes to 0, the code output holds its last value and illegal_pattern is set. The event does not enter the sequence FSM.
- Sequence FSM, run on accepted state events only:
  - SYNC: wait for accepted blank (15), then go to IDLE. Other codes are ignored and raise no error.
  - IDLE: code 3 -> BREW. Latch brew_type=type_code (if type_valid=0, raise seq_error and go to SYNC). Set expected=4.
  - BREW: code==expected -> advance; expected increments up to 8. Accepting 8 -> FINISH.
  - FINISH: blank -> pulse brew_done, increment brew_count[brew_type], clear led_seen, go to IDLE.
  - Any other accepted state code in IDLE, BREW or FINISH: set seq_error and go to SYNC.
- Type changes during BREW or FINISH update type_code but do not alter brew_type.
- Counters saturate at 2^CNT_W-1.
- led_seen is set on any synchronized led!=0. If brew_done and a nonzero led occur in the same cycle, the clear wins.
- clear_errors clears illegal_pattern and seq_error. If a set and a clear occur in the same cycle, the set wins.
- A type event and a state event accepted in the same cycle: the type is updated first, so a brew starting that cycle latches the new type.

Decomposition:
- Package coffee_panel_pkg holds:
  - SEG_LUT: 16 x 7-bit constant array, shared with the display decoder.
  - Constants CH_BLANK=15, ST_FIRST=3, ST_LAST=8, N_TYPES=3.
  - Enum mon_state_t {SYNC, IDLE, BREW, FINISH}.
- One sub-module: seg_stable_decode, instantiated twice. It contains the synchronizer, the stability counter and the LUT inverse match, and outputs an accept pulse, code and legal flag.

Test Plan:
- Reset, drive blank state and type 0 patterns -> state_valid=1, state_code=15, type_code=0 after 6 cycles (STABLE_CYCLES=4). No errors; FSM in IDLE.
- Type 1, then state sequence 3,4,5,6,7,8,blank with each step held 10 cycles, led=5'b00001 during 8 -> one brew_done pulse, brew_count slice1=1, slices 0 and 2 = 0, led_seen cleared.
- State 3,4,6 -> seq_error=1 on accepting 6; brew_count unchanged. clear_errors -> seq_error=0. A blank then a full sequence counts normally.
- Glitch pattern 7'h55 on seg_state held 3 cycles, then back -> no event and no illegal_pattern. The same pattern held 8 cycles -> illegal_pattern=1, state_valid=0.
- Type changed from 2 to 0 mid-brew, then the sequence completes -> slice2 increments, type_code=0.
- Preload 255 brews on type 0 with CNT_W=8, run one more -> stays 255. Assert reset during BREW -> all counts 0, FSM SYNC, no brew_done.
